// File: rtl/mandel_pkg.sv
// Shared types and constants for the Mandelbrot line engine: Q4.28 fixed point,
// escape depth, pixel job record and the two FSM state encodings.
package mandel_pkg;

    localparam int WORD_LENGTH = 32;
    localparam int FRAC        = 28;

    typedef logic signed [WORD_LENGTH-1:0]   fixed_t;
    typedef logic signed [2*WORD_LENGTH-1:0] wide_t;
    typedef logic        [2*WORD_LENGTH:0]   mag_t;
    typedef logic        [9:0]               depth_t;
    typedef logic        [9:0]               xcoord_t;

    // |z|^2 threshold of 4.0 expressed in the full-width product scale.
    localparam mag_t ESCAPE_LIMIT = mag_t'(4) << (2 * FRAC);

    localparam fixed_t REAL_CENTER_Q = -32'sd201326592;  // -0.75
    localparam fixed_t IMAG_CENTER_Q = 32'sd26843545;    //  0.1
    localparam fixed_t STEP_Q        = 32'sd1258291;     //  3/640

    typedef struct packed {
        xcoord_t x;
        fixed_t  c_re;
        fixed_t  c_im;
    } job_t;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} line_state_t;
    typedef enum logic [1:0] {U_IDLE, U_RUN, U_DONE} unit_state_t;

endpackage

// File: rtl/mandel_line_engine_if.sv
// Control handshake and line-buffer write port of the Mandelbrot line engine.
interface mandel_line_engine_if #(
    parameter int ADDR_W = 10
);
    import mandel_pkg::*;

    logic              start;
    logic              busy;
    logic              module_done;
    depth_t            depth_out;
    logic              we_out;
    logic [ADDR_W-1:0] addr_out;
    logic [8:0]        line_y;

    modport master (input start, output busy, module_done, depth_out, we_out, addr_out, line_y);
    modport slave  (output start, input busy, module_done, depth_out, we_out, addr_out, line_y);

endinterface

// File: rtl/mandel_iter_unit.sv
// One escape-time iteration unit: loads a pixel job, iterates z = z^2 + c one
// step per cycle and holds the finished depth until the collector grants it.
module mandel_iter_unit
    import mandel_pkg::*;
#(
    parameter int MAX_ITER = 256
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    load,
    input  job_t    job,
    output logic    busy,
    output logic    res_valid,
    output depth_t  res_depth,
    output xcoord_t res_x,
    input  logic    grant
);

    unit_state_t state, state_nxt;
    fixed_t      z_re, z_im, c_re, c_im;
    depth_t      iter;
    xcoord_t     x_q;
    wide_t       rr, ii, ri;
    mag_t        mag;
    logic        escape, capped;

    always_comb begin
        rr     = wide_t'(z_re) * wide_t'(z_re);
        ii     = wide_t'(z_im) * wide_t'(z_im);
        ri     = wide_t'(z_re) * wide_t'(z_im);
        mag    = mag_t'(rr) + mag_t'(ii);
        escape = mag > ESCAPE_LIMIT;
        capped = iter == depth_t'(MAX_ITER);
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            U_IDLE:  if (load) state_nxt = U_RUN;
            U_RUN:   if (escape || capped) state_nxt = U_DONE;
            U_DONE:  if (grant) state_nxt = U_IDLE;
            default: state_nxt = U_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) state <= U_IDLE;
        else       state <= state_nxt;
    end

    // NOTE: the datapath is not reset; a job load initialises every register it relies on.
    always_ff @(posedge clk) begin
        if (state == U_IDLE && load) begin
            z_re <= '0;
            z_im <= '0;
            iter <= '0;
            c_re <= job.c_re;
            c_im <= job.c_im;
            x_q  <= job.x;
        end else if (state == U_RUN && !escape && !capped) begin
            z_re <= fixed_t'(rr >>> FRAC) - fixed_t'(ii >>> FRAC) + c_re;
            z_im <= (fixed_t'(ri >>> FRAC) <<< 1) + c_im;
            iter <= iter + depth_t'(1);
        end
    end

    // The iteration count freezes on finish, so it is the depth in both exit cases.
    assign busy      = state != U_IDLE;
    assign res_valid = state == U_DONE;
    assign res_depth = iter;
    assign res_x     = x_q;

endmodule

// File: rtl/mandel_line_engine.sv
// Computes one line of Mandelbrot escape depths per start pulse across NUM_ENGINES units.
// Optional MANDEL_LINE_CYCLES_EN adds a line_cycles output counting start..module_done.
module mandel_line_engine
    import mandel_pkg::*;
#(
    parameter int     X_SIZE      = 640,
    parameter int     Y_SIZE      = 480,
    parameter int     NUM_ENGINES = 4,
    parameter int     MAX_ITER    = 256,
    parameter fixed_t REAL_CENTER = REAL_CENTER_Q,
    parameter fixed_t IMAG_CENTER = IMAG_CENTER_Q,
    parameter fixed_t STEP        = STEP_Q
) (
    input  logic clk,
    input  logic reset,
`ifdef MANDEL_LINE_CYCLES_EN
    output logic [19:0] line_cycles,
`endif
    mandel_line_engine_if.master bus
);

    localparam int ADDR_W = $clog2(X_SIZE);
    localparam int CNT_W  = $clog2(X_SIZE + 1);
    localparam int ENG_W  = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;
    // Left-most pixel and top line coordinates; everything else is reached by stepping.
    localparam fixed_t RE_START = fixed_t'(REAL_CENTER - (X_SIZE / 2) * STEP);
    localparam fixed_t IM_START = fixed_t'(IMAG_CENTER + (Y_SIZE / 2) * STEP);

    line_state_t state, state_nxt;
    logic [CNT_W-1:0] issue_cnt, wr_cnt;
    fixed_t c_re_acc, c_im_line;
    job_t   job;

    logic [NUM_ENGINES-1:0] u_busy, u_valid, u_load, u_grant;
    depth_t  u_depth [NUM_ENGINES];
    xcoord_t u_x     [NUM_ENGINES];
    logic             issue_ok, gnt_ok;
    logic [ENG_W-1:0] issue_idx, gnt_idx;

    for (genvar g = 0; g < NUM_ENGINES; g++) begin : g_unit
        mandel_iter_unit #(.MAX_ITER(MAX_ITER)) u_iter (
            .clk       (clk),
            .reset     (reset),
            .load      (u_load[g]),
            .job       (job),
            .busy      (u_busy[g]),
            .res_valid (u_valid[g]),
            .res_depth (u_depth[g]),
            .res_x     (u_x[g]),
            .grant     (u_grant[g])
        );
    end

    assign job = '{x: xcoord_t'(issue_cnt), c_re: c_re_acc, c_im: c_im_line};

    // Descending scans leave the lowest qualifying index selected.
    always_comb begin
        issue_ok  = 1'b0;
        issue_idx = '0;
        gnt_ok    = 1'b0;
        gnt_idx   = '0;
        u_load    = '0;
        u_grant   = '0;
        for (int i = NUM_ENGINES - 1; i >= 0; i--) begin
            if (!u_busy[i]) begin
                issue_ok  = 1'b1;
                issue_idx = ENG_W'(i);
            end
            if (u_valid[i]) begin
                gnt_ok  = 1'b1;
                gnt_idx = ENG_W'(i);
            end
        end
        issue_ok = issue_ok && state == S_RUN && issue_cnt < CNT_W'(X_SIZE);
        if (issue_ok) u_load[issue_idx] = 1'b1;
        if (gnt_ok)   u_grant[gnt_idx]  = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (bus.start) state_nxt = S_RUN;
            S_RUN:   if (bus.we_out && wr_cnt == CNT_W'(X_SIZE - 1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
        bus.busy        = state != S_IDLE;
        bus.module_done = state == S_DONE;
    end

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            issue_cnt     <= '0;
            wr_cnt        <= '0;
            c_re_acc      <= RE_START;
            c_im_line     <= IM_START;
            bus.line_y    <= '0;
            bus.we_out    <= 1'b0;
            bus.depth_out <= '0;
            bus.addr_out  <= '0;
        end else begin
            bus.we_out <= gnt_ok;
            if (gnt_ok) begin
                bus.depth_out <= u_depth[gnt_idx];
                bus.addr_out  <= ADDR_W'(u_x[gnt_idx]);
            end
            if (state == S_IDLE && bus.start) begin
                issue_cnt <= '0;
                wr_cnt    <= '0;
                c_re_acc  <= RE_START;
            end else begin
                if (issue_ok) begin
                    issue_cnt <= issue_cnt + CNT_W'(1);
                    c_re_acc  <= c_re_acc + STEP;
                end
                if (bus.we_out) wr_cnt <= wr_cnt + CNT_W'(1);
            end
            // Imaginary coordinate decreases down the frame and rewinds on wrap.
            if (state == S_DONE) begin
                if (bus.line_y == 9'(Y_SIZE - 1)) begin
                    bus.line_y <= '0;
                    c_im_line  <= IM_START;
                end else begin
                    bus.line_y <= bus.line_y + 9'd1;
                    c_im_line  <= c_im_line - STEP;
                end
            end
        end
    end

`ifdef MANDEL_LINE_CYCLES_EN
    always_ff @(posedge clk) begin
        if (reset)                                 line_cycles <= '0;
        else if (state == S_IDLE && bus.start)     line_cycles <= 20'd1;
        else if (state != S_IDLE && line_cycles != '1) line_cycles <= line_cycles + 20'd1;
    end
`endif

endmodule

// File: tb/tb_mandel_line_engine.sv
// Directed bench: table-driven unit vectors, full default-size lines against a
// Q4.28 golden model, dropped starts, mid-line reset and a 480-line wrap run.
module tb_mandel_line_engine;
    import mandel_pkg::*;

    localparam int AX = 640, AY = 480, AN = 4, AM = 256;
    localparam int BX = 8,   BY = 480, BN = 3, BM = 8;
    localparam fixed_t ONE = 32'sd268435456;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mandel_line_engine_if #(.ADDR_W($clog2(AX))) bus_a ();
    mandel_line_engine_if #(.ADDR_W($clog2(BX))) bus_b ();

`ifdef MANDEL_LINE_CYCLES_EN
    logic [19:0] lc_a, lc_b;
`endif

    mandel_line_engine #(.X_SIZE(AX), .Y_SIZE(AY), .NUM_ENGINES(AN), .MAX_ITER(AM)) dut_a (
        .clk(clk), .reset(reset),
`ifdef MANDEL_LINE_CYCLES_EN
        .line_cycles(lc_a),
`endif
        .bus(bus_a));

    mandel_line_engine #(.X_SIZE(BX), .Y_SIZE(BY), .NUM_ENGINES(BN), .MAX_ITER(BM)) dut_b (
        .clk(clk), .reset(reset),
`ifdef MANDEL_LINE_CYCLES_EN
        .line_cycles(lc_b),
`endif
        .bus(bus_b));

    logic    u_load, u_grant, u_busy, u_valid;
    job_t    u_job;
    depth_t  u_depth;
    xcoord_t u_x;

    mandel_iter_unit #(.MAX_ITER(256)) unit (
        .clk(clk), .reset(reset), .load(u_load), .job(u_job), .busy(u_busy),
        .res_valid(u_valid), .res_depth(u_depth), .res_x(u_x), .grant(u_grant));

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Golden escape-depth model with Q4.28 truncation of each product.
    function automatic int model_depth(input int cre, input int cim, input int max_iter);
        int zr = 0, zi = 0, nr, ni;
        longint rr, ii, ri;
        for (int it = 0; it <= max_iter; it++) begin
            rr = longint'(zr) * longint'(zr);
            ii = longint'(zi) * longint'(zi);
            if (rr + ii > (longint'(4) << 56)) return it;
            if (it == max_iter) return max_iter;
            ri = longint'(zr) * longint'(zi);
            nr = int'(rr >>> 28) - int'(ii >>> 28) + cre;
            ni = int'(ri >>> 28) * 2 + cim;
            zr = nr;
            zi = ni;
        end
        return max_iter;
    endfunction

    function automatic int coord_re(input int xs, input int x);
        return REAL_CENTER_Q + (x - xs / 2) * STEP_Q;
    endfunction

    function automatic int coord_im(input int ys, input int y);
        return IMAG_CENTER_Q - (y - ys / 2) * STEP_Q;
    endfunction

    bit seen_a [AX];
    bit seen_b [BX];
    int wr_a, wr_b, done_a, done_b, ey_a, ey_b;

    always @(negedge clk) begin
        if (bus_a.we_out === 1'b1) begin
            wr_a++;
            check("a_addr_range", bus_a.addr_out < AX, 1);
            check("a_addr_once", seen_a[bus_a.addr_out], 0);
            seen_a[bus_a.addr_out] = 1'b1;
            check("a_depth", bus_a.depth_out,
                  model_depth(coord_re(AX, int'(bus_a.addr_out)), coord_im(AY, ey_a), AM));
        end
        if (bus_a.module_done === 1'b1) done_a++;
        if (bus_b.we_out === 1'b1) begin
            wr_b++;
            check("b_addr_once", seen_b[bus_b.addr_out], 0);
            seen_b[bus_b.addr_out] = 1'b1;
            check("b_depth", bus_b.depth_out,
                  model_depth(coord_re(BX, int'(bus_b.addr_out)), coord_im(BY, ey_b), BM));
            if (ey_b == BY / 2 && int'(bus_b.addr_out) == BX / 2)
                check("b_center_px", bus_b.depth_out, model_depth(REAL_CENTER_Q, IMAG_CENTER_Q, BM));
        end
        if (bus_b.module_done === 1'b1) done_b++;
    end

    task automatic set_start(input bit use_b, input logic v);
        if (use_b) bus_b.start = v;
        else       bus_a.start = v;
    endtask

    // One line: start, optional dropped starts mid-line and on module_done, then totals.
    task automatic run_line(input bit use_b, input int exp_y, input bit mid_start,
                            input bit done_start, input int budget);
        int cyc, xs, ys, nseen;
        bit saw_done;
        xs = use_b ? BX : AX;
        ys = use_b ? BY : AY;
        if (use_b) begin
            foreach (seen_b[i]) seen_b[i] = 1'b0;
            wr_b = 0; done_b = 0; ey_b = exp_y;
        end else begin
            foreach (seen_a[i]) seen_a[i] = 1'b0;
            wr_a = 0; done_a = 0; ey_a = exp_y;
        end
        check("line_y_before", use_b ? bus_b.line_y : bus_a.line_y, exp_y);
        set_start(use_b, 1'b1);
        @(negedge clk);
        set_start(use_b, 1'b0);
        check("busy_after_start", use_b ? bus_b.busy : bus_a.busy, 1);
        cyc = 0;
        saw_done = 1'b0;
        while (!saw_done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (mid_start) set_start(use_b, cyc == 50);
            if ((use_b ? bus_b.module_done : bus_a.module_done) === 1'b1) begin
                saw_done = 1'b1;
                if (done_start) begin
                    set_start(use_b, 1'b1);
                    @(negedge clk);
                    set_start(use_b, 1'b0);
                end
            end
        end
        set_start(use_b, 1'b0);
        check("line_done_seen", saw_done, 1);
        repeat (3) @(negedge clk);
        nseen = 0;
        if (use_b) foreach (seen_b[i]) nseen += int'(seen_b[i]);
        else       foreach (seen_a[i]) nseen += int'(seen_a[i]);
        check("busy_after_done", use_b ? bus_b.busy : bus_a.busy, 0);
        check("write_count", use_b ? wr_b : wr_a, xs);
        check("addr_coverage", nseen, xs);
        check("done_pulses", use_b ? done_b : done_a, 1);
        check("line_y_after", use_b ? bus_b.line_y : bus_a.line_y, (exp_y + 1) % ys);
    endtask

    typedef struct packed {
        fixed_t  c_re;
        fixed_t  c_im;
        xcoord_t x;
        depth_t  exp_depth;
    } uvec_t;

    uvec_t uv [7];

    initial begin
        int cyc, n;
        uv[0] = '{c_re: ONE,         c_im: '0,          x: 10'd1,   exp_depth: 10'd3};
        uv[1] = '{c_re: 2 * ONE,     c_im: '0,          x: 10'd2,   exp_depth: 10'd2};
        uv[2] = '{c_re: -2 * ONE,    c_im: '0,          x: 10'd639, exp_depth: 10'd256};
        uv[3] = '{c_re: '0,          c_im: '0,          x: 10'd0,   exp_depth: 10'd256};
        uv[4] = '{c_re: ONE / 2,     c_im: '0,          x: 10'd321, exp_depth: 10'd5};
        uv[5] = '{c_re: '0,          c_im: ONE,         x: 10'd77,  exp_depth: 10'd256};
        uv[6] = '{c_re: '0,          c_im: -2 * ONE,    x: 10'd512, exp_depth: 10'd2};

        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        u_load = 1'b0;
        u_grant = 1'b0;
        u_job = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", bus_a.busy, 0);
        check("rst_done", bus_a.module_done, 0);
        check("rst_we", bus_a.we_out, 0);
        check("rst_depth", bus_a.depth_out, 0);
        check("rst_addr", bus_a.addr_out, 0);
        check("rst_line_y", bus_a.line_y, 0);
        check("rst_unit_busy", u_busy, 0);

        for (int i = 0; i < 7; i++) begin
            u_job = '{x: uv[i].x, c_re: uv[i].c_re, c_im: uv[i].c_im};
            u_load = 1'b1;
            @(negedge clk);
            u_load = 1'b0;
            cyc = 0;
            while (u_valid !== 1'b1 && cyc < 400) begin
                @(negedge clk);
                cyc++;
            end
            check("unit_finished", u_valid, 1);
            check("unit_depth", u_depth, uv[i].exp_depth);
            check("unit_x", u_x, uv[i].x);
            @(negedge clk);
            check("unit_holds", u_valid, 1);
            u_grant = 1'b1;
            @(negedge clk);
            u_grant = 1'b0;
            check("unit_released", u_busy, 0);
        end

        run_line(1'b0, 0, 1'b1, 1'b1, 20000);

        foreach (seen_a[i]) seen_a[i] = 1'b0;
        ey_a = 1;
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        n = 0;
        cyc = 0;
        while (n < 300 && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            if (bus_a.we_out === 1'b1) n++;
        end
        check("reached_write_300", n, 300);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midrst_we", bus_a.we_out, 0);
        check("midrst_busy", bus_a.busy, 0);
        check("midrst_line_y", bus_a.line_y, 0);
        check("midrst_done", bus_a.module_done, 0);
        check("midrst_addr", bus_a.addr_out, 0);
        check("midrst_depth", bus_a.depth_out, 0);

        run_line(1'b0, 0, 1'b0, 1'b0, 20000);

        for (int y = 0; y < BY; y++) run_line(1'b1, y, 1'b0, 1'b0, 150);
        check("b_wrap_line_y", bus_b.line_y, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #950000;
        $display("FAIL watchdog: simulation did not complete, %0d compared so far", n_cmp);
        $fatal(1, "watchdog expired");
    end

endmodule
